// File: rtl/ws281x_frame_ctrl.sv
// WS281x frame controller: pixel buffer with global brightness scaling, frame
// sequencing toward a serial bit driver, and optional periodic auto-refresh.
module ws281x_frame_ctrl #(
  parameter int NumLeds       = 8,
  parameter int RefreshCycles = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        px_we_i,
  input  logic [7:0]  px_idx_i,
  input  logic [23:0] px_data_i,
  input  logic [8:0]  num_leds_i,
  input  logic [7:0]  brightness_i,
  input  logic        start_i,
  input  logic        auto_en_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        drv_go_o,
  input  logic        drv_idle_i,
  output logic [23:0] drv_data_o,
  output logic        drv_data_valid_o,
  output logic        drv_data_last_o,
  input  logic        drv_ack_i
);

  localparam int IdxW = (NumLeds > 1) ? $clog2(NumLeds) : 1;
  localparam int CntW = (RefreshCycles > 1) ? $clog2(RefreshCycles) : 1;
  localparam logic [8:0] NumLedsW = 9'(NumLeds);
  localparam logic [CntW-1:0] CntMax = CntW'(RefreshCycles - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_STREAM  = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  // 8-bit channel times (brightness+1), keeping product bits 15:8.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, c} * ({9'd0, b} + 17'd1);
    return prod[15:8];
  endfunction

  function automatic logic [8:0] clip_len(input logic [8:0] n);
    logic [8:0] res;
    if (n > NumLedsW) begin
      res = NumLedsW;
    end else begin
      res = n;
    end
    return res;
  endfunction

  state_e          r_state, w_next_state;
  logic [8:0]      r_idx, w_idx_next;
  logic [8:0]      r_len, w_len_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic            r_done, w_done_next;
  logic [23:0]     r_buf [NumLeds];
  logic [8:0]      w_len_clip;
  logic            w_go, w_valid, w_last;
  logic [23:0]     w_px;

  // Pixel buffer; writes are accepted at any time, so an acknowledged pixel
  // keeps the value read combinationally before this edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumLeds; i++) begin
        r_buf[i] <= 24'd0;
      end
    end else if (px_we_i && ({1'b0, px_idx_i} < NumLedsW)) begin
      r_buf[px_idx_i[IdxW-1:0]] <= px_data_i;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_idx   <= 9'd0;
      r_len   <= 9'd0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_idx_next;
      r_len   <= w_len_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state logic and driver handshake decode.
  always_comb begin
    w_next_state = r_state;
    w_idx_next   = r_idx;
    w_len_next   = r_len;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    w_go         = 1'b0;
    w_valid      = 1'b0;
    w_len_clip   = clip_len(num_leds_i);
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_len_next = w_len_clip;
          w_idx_next = 9'd0;
          if (w_len_clip == 9'd0) begin
            w_done_next = 1'b1;
          end else begin
            w_next_state = ST_START;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_START: begin
        w_go    = drv_idle_i;
        w_valid = drv_idle_i;
        if (w_valid && drv_ack_i) begin
          if (r_len == 9'd1) begin
            w_next_state = ST_DRAIN;
          end else begin
            w_next_state = ST_STREAM;
            w_idx_next   = r_idx + 9'd1;
          end
        end else begin
          w_next_state = ST_START;
        end
      end
      ST_STREAM: begin
        w_valid = 1'b1;
        if (drv_ack_i) begin
          if (r_idx == (r_len - 9'd1)) begin
            w_next_state = ST_DRAIN;
          end else begin
            w_idx_next = r_idx + 9'd1;
          end
        end else begin
          w_next_state = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (drv_idle_i) begin
          w_done_next  = 1'b1;
          w_cnt_next   = '0;
          w_next_state = auto_en_i ? ST_HOLDOFF : ST_IDLE;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_HOLDOFF: begin
        if (!auto_en_i) begin
          w_next_state = ST_IDLE;
          w_cnt_next   = '0;
        end else if (start_i || (r_cnt == CntMax)) begin
          w_len_next = w_len_clip;
          w_idx_next = 9'd0;
          w_cnt_next = '0;
          // An empty refresh completes at once and re-arms the holdoff timer.
          if (w_len_clip == 9'd0) begin
            w_done_next = 1'b1;
          end else begin
            w_next_state = ST_START;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_idx_next   = 9'd0;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Buffer read at the current pixel index.
  always_comb begin
    w_px = 24'd0;
    if (r_idx < NumLedsW) begin
      w_px = r_buf[r_idx[IdxW-1:0]];
    end else begin
      w_px = 24'd0;
    end
  end

  assign w_last = w_valid && (r_idx == (r_len - 9'd1));

  assign busy_o           = (r_state == ST_START) || (r_state == ST_STREAM) || (r_state == ST_DRAIN);
  assign frame_done_o     = r_done;
  assign drv_go_o         = w_go;
  assign drv_data_valid_o = w_valid;
  assign drv_data_last_o  = w_last;
  assign drv_data_o       = {scale_ch(w_px[15:8], brightness_i),
                             scale_ch(w_px[23:16], brightness_i),
                             scale_ch(w_px[7:0], brightness_i)};

endmodule
